// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with arbitrary depth, exact occupancy count, and either a
// registered (latency-1) read port or a first-word-fall-through read port.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ALMOST_WR  = 2,
  parameter int ALMOST_RD  = 1,
  parameter int FWFT       = 0,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  wr_ack,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [CW-1:0]         data_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(FIFO_DEPTH - ALMOST_WR);
  localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_RD);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_next, mem_count;
  logic                  rd_acc, wr_acc;
  logic                  head_load, head_bypass, rd_adv;

  // In FWFT mode the head word lives in dout but is still counted; mem_count
  // is the number of stored words not yet copied into dout.
  always_comb begin
    empty      = (FWFT != 0) ? !valid : (data_count == '0);
    rd_acc     = rd_en & !empty;
    wr_acc     = wr_en & (!full | rd_acc);
    count_next = data_count;
    if (wr_acc && !rd_acc) begin
      count_next = data_count + 1'b1;
    end else if (!wr_acc && rd_acc) begin
      count_next = data_count - 1'b1;
    end
    mem_count   = data_count - CW'(valid);
    head_load   = (FWFT != 0) & (rd_acc | !valid) & (mem_count != '0);
    // Popping the last word while a new one arrives: forward din straight
    // into dout so valid never drops; the word is also written to memory
    // and rd_ptr advances past it to keep both pointers aligned.
    head_bypass = (FWFT != 0) & rd_acc & (mem_count == '0) & wr_acc;
    rd_adv      = (FWFT != 0) ? (head_load | head_bypass) : rd_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      dout         <= '0;
      valid        <= 1'b0;
      wr_ack       <= 1'b0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      data_count   <= count_next;
      full         <= (count_next == DEPTH_C);
      almost_full  <= (count_next >= AF_LVL);
      almost_empty <= (count_next <= AE_LVL);
      wr_ack       <= wr_acc;
      overflow     <= wr_en & !wr_acc;
      underflow    <= rd_en & !rd_acc;
      if (FWFT != 0) begin
        if (head_load) begin
          dout  <= mem[rd_ptr];
          valid <= 1'b1;
        end else if (head_bypass) begin
          dout  <= din;
          valid <= 1'b1;
        end else if (rd_acc) begin
          valid <= 1'b0;
        end
      end else begin
        valid <= rd_acc;
        if (rd_acc) begin
          dout <= mem[rd_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: three instances (default, depth 6, FWFT) share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_sync_fifo_fwft;

  typedef struct packed {
    logic [7:0] dout;
    logic       valid;
    logic       wr_ack;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
    logic [3:0] cnt;
  } obs_t;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    obs_t       exp;
  } row_t;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  logic [7:0] din;

  logic [7:0] dout_a [3];
  logic       valid_a [3], ack_a [3], full_a [3], empty_a [3];
  logic       af_a [3], ae_a [3], ovf_a [3], udf_a [3];
  logic [3:0] cnt0, cnt2;
  logic [2:0] cnt1;
  obs_t       act [3];

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0]  mq [3][$];
  logic [7:0]  m_dout [3];
  logic        m_valid [3], m_ack [3], m_ovf [3], m_udf [3];
  int unsigned depth_k [3] = '{8, 6, 8};
  bit          fw_k [3]    = '{1'b0, 1'b0, 1'b1};
  string       nm [3]      = '{"std", "d6", "fwft"};

  row_t rows [20];

  always #5 clk = ~clk;

  sync_fifo_fwft u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_a[0]), .valid(valid_a[0]), .wr_ack(ack_a[0]), .full(full_a[0]),
    .empty(empty_a[0]), .almost_full(af_a[0]), .almost_empty(ae_a[0]),
    .overflow(ovf_a[0]), .underflow(udf_a[0]), .data_count(cnt0)
  );

  sync_fifo_fwft #(.FIFO_DEPTH(6)) u_d6 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_a[1]), .valid(valid_a[1]), .wr_ack(ack_a[1]), .full(full_a[1]),
    .empty(empty_a[1]), .almost_full(af_a[1]), .almost_empty(ae_a[1]),
    .overflow(ovf_a[1]), .underflow(udf_a[1]), .data_count(cnt1)
  );

  sync_fifo_fwft #(.FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout_a[2]), .valid(valid_a[2]), .wr_ack(ack_a[2]), .full(full_a[2]),
    .empty(empty_a[2]), .almost_full(af_a[2]), .almost_empty(ae_a[2]),
    .overflow(ovf_a[2]), .underflow(udf_a[2]), .data_count(cnt2)
  );

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      act[k].dout   = dout_a[k];
      act[k].valid  = valid_a[k];
      act[k].wr_ack = ack_a[k];
      act[k].full   = full_a[k];
      act[k].empty  = empty_a[k];
      act[k].af     = af_a[k];
      act[k].ae     = ae_a[k];
      act[k].ovf    = ovf_a[k];
      act[k].udf    = udf_a[k];
      act[k].cnt    = 4'd0;
    end
    act[0].cnt = cnt0;
    act[1].cnt = {1'b0, cnt1};
    act[2].cnt = cnt2;
  end

  function automatic row_t row(logic w, logic r, logic [7:0] d, logic [7:0] o,
                               logic v, logic ack, logic fl, logic emp, logic af,
                               logic ae, logic ovf, logic udf, logic [3:0] cnt);
    row_t x;
    x.wr  = w;
    x.rd  = r;
    x.din = d;
    x.exp = '{o, v, ack, fl, emp, af, ae, ovf, udf, cnt};
    return x;
  endfunction

  // Behavioural reference: a word queue plus the visible output register.
  task automatic model_step(input int k, input logic r, input logic w,
                            input logic rd_i, input logic [7:0] d);
    int unsigned sz;
    logic emp, ra, wa, nv;
    logic [7:0] popped;
    if (r) begin
      mq[k].delete();
      m_dout[k] = 8'd0;
      m_valid[k] = 1'b0;
      m_ack[k] = 1'b0;
      m_ovf[k] = 1'b0;
      m_udf[k] = 1'b0;
      return;
    end
    sz = mq[k].size();
    emp = fw_k[k] ? !m_valid[k] : (sz == 0);
    ra = rd_i && !emp;
    wa = w && ((sz < depth_k[k]) || ra);
    popped = 8'd0;
    if (ra) popped = mq[k].pop_front();
    if (wa) mq[k].push_back(d);
    if (fw_k[k]) begin
      nv = m_valid[k] ? (ra ? (mq[k].size() > 0) : 1'b1) : (sz > 0);
      if (nv) m_dout[k] = mq[k][0];
      m_valid[k] = nv;
    end else begin
      m_valid[k] = ra;
      if (ra) m_dout[k] = popped;
    end
    m_ack[k] = wa;
    m_ovf[k] = w && !wa;
    m_udf[k] = rd_i && !ra;
  endtask

  function automatic obs_t model_obs(int k);
    obs_t o;
    int unsigned sz;
    sz = mq[k].size();
    o.dout   = m_dout[k];
    o.valid  = m_valid[k];
    o.wr_ack = m_ack[k];
    o.full   = (sz == depth_k[k]);
    o.empty  = fw_k[k] ? !m_valid[k] : (sz == 0);
    o.af     = (sz >= depth_k[k] - 2);
    o.ae     = (sz <= 1);
    o.ovf    = m_ovf[k];
    o.udf    = m_udf[k];
    o.cnt    = 4'(sz);
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h required=%h (dout,v,ack,full,empty,af,ae,ovf,udf,cnt)",
               name, $time, got, exp);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd_i, input logic [7:0] d);
    rst = r;
    wr_en = w;
    rd_en = rd_i;
    din = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, r, w, rd_i, d);
    #1;
    for (int k = 0; k < 3; k++) check(nm[k], act[k], model_obs(k));
  endtask

  initial begin
    obs_t rst_obs;
    int nexp;
    int exp4 [8] = '{14, 15, 16, 17, 1, 2, 3, 4};
    logic r, w, rd_i;
    int wp, rp;

    rows[0]  = row(1, 0, 17, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    rows[1]  = row(1, 0, 20, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2);
    rows[2]  = row(1, 0, 32, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3);
    rows[3]  = row(1, 0, 33, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4);
    rows[4]  = row(1, 0, 34, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5);
    rows[5]  = row(1, 0, 35, 0, 0, 1, 0, 0, 1, 0, 0, 0, 6);
    rows[6]  = row(1, 0, 36, 0, 0, 1, 0, 0, 1, 0, 0, 0, 7);
    rows[7]  = row(1, 0, 37, 0, 0, 1, 1, 0, 1, 0, 0, 0, 8);
    rows[8]  = row(1, 0, 38, 0, 0, 0, 1, 0, 1, 0, 1, 0, 8);
    rows[9]  = row(1, 0, 39, 0, 0, 0, 1, 0, 1, 0, 1, 0, 8);
    rows[10] = row(0, 1, 0, 17, 1, 0, 0, 0, 1, 0, 0, 0, 7);
    rows[11] = row(0, 1, 0, 20, 1, 0, 0, 0, 1, 0, 0, 0, 6);
    rows[12] = row(0, 1, 0, 32, 1, 0, 0, 0, 0, 0, 0, 0, 5);
    rows[13] = row(0, 1, 0, 33, 1, 0, 0, 0, 0, 0, 0, 0, 4);
    rows[14] = row(0, 1, 0, 34, 1, 0, 0, 0, 0, 0, 0, 0, 3);
    rows[15] = row(0, 1, 0, 35, 1, 0, 0, 0, 0, 0, 0, 0, 2);
    rows[16] = row(0, 1, 0, 36, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    rows[17] = row(0, 1, 0, 37, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    rows[18] = row(0, 1, 0, 37, 0, 0, 0, 1, 0, 1, 0, 1, 0);
    rows[19] = row(0, 1, 0, 37, 0, 0, 0, 1, 0, 1, 0, 1, 0);
    rst_obs = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'd0;

    // reset with both requests asserted
    repeat (3) step(1, 1, 1, 8'hAA);
    for (int k = 0; k < 3; k++) check({"reset_", nm[k]}, act[k], rst_obs);

    // fill then drain, default instance against fixed vectors
    for (int i = 0; i < 20; i++) begin
      step(0, rows[i].wr, rows[i].rd, rows[i].din);
      check($sformatf("table%0d", i), act[0], rows[i].exp);
    end

    // full with simultaneous read and write
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(10 + i));
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 1, 8'(i));
      check_val("conc_count", int'(cnt0), 8);
      check_val("conc_ovf", int'(ovf_a[0]), 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 8'd0);
      check_val("conc_drain", {valid_a[0], dout_a[0]}, 256 + exp4[i]);
    end

    // depth-6 pointer wrap
    step(1, 0, 0, 8'd0);
    nexp = 1;
    for (int b = 0; b < 5; b++) begin
      for (int i = 1; i <= 4; i++) step(0, 1, 0, 8'(4 * b + i));
      for (int i = 0; i < 4; i++) begin
        step(0, 0, 1, 8'd0);
        check_val("wrap_seq", {valid_a[1], dout_a[1]}, 256 + nexp);
        nexp++;
      end
    end

    // FWFT fall-through and back-to-back pops
    step(1, 0, 0, 8'd0);
    step(0, 1, 0, 8'd5);
    check_val("fwft_latency", int'(valid_a[2]), 0);
    step(0, 0, 0, 8'd0);
    check_val("fwft_fall", {valid_a[2], dout_a[2]}, 256 + 5);
    step(0, 1, 0, 8'd6);
    step(0, 1, 0, 8'd7);
    for (int i = 0; i < 3; i++) begin
      check_val("fwft_head", {valid_a[2], dout_a[2]}, 256 + 5 + i);
      step(0, 0, 1, 8'd0);
    end
    check_val("fwft_drained", {valid_a[2], empty_a[2]}, 1);

    // randomized traffic with shifting read/write bias
    step(1, 0, 0, 8'd0);
    wp = 50; rp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        wp = $urandom_range(10, 90);
        rp = $urandom_range(10, 90);
      end
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 99) < wp);
      rd_i = ($urandom_range(0, 99) < rp);
      step(r, w, rd_i, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
